// File: rtl/seg7_pkg.sv
// Seven-segment patterns ({g,f,e,d,c,b,a}, active-high) and BCD helpers shared
// by the digit cells and the display scanner.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Mod-10 increment, gated by inc.
  function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic inc);
    if (!inc) return d;
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD ripple chain; carry_out is combinational so the whole
// chain settles before a single edge.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       carry_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_q;

  assign digit     = digit_q;
  assign carry_out = carry_in && (digit_q == 4'd9);

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!reset) digit_q <= 4'd0;
    else        digit_q <= bcd_next(digit_q, carry_in);
  end

endmodule

// File: rtl/count_display_scan.sv
// Extends an upstream mod-10 units count into a DIGITS-wide BCD value and
// scans it onto a multiplexed seven-segment display.
module count_display_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          count_in,
  input  logic                hold,
  output logic [4*DIGITS-1:0] value_bcd,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an,
  output logic                overflow,
  output logic                err
);

  localparam int SCAN_W  = $clog2(DIGITS);
  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam logic INV   = (ACTIVE_LOW != 0);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(DIGITS - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [DIGITS-1:0]  AN_RST     = DIGITS'(1);

  logic [3:0]          count_q;
  logic                count_legal;
  logic [DIGITS-1:0]   carry;
  logic [4*DIGITS-1:0] value_d;
  logic [4*DIGITS-1:0] latch_q;
  logic                overflow_q, err_q;
  logic [PRESC_W-1:0]  presc_q;
  logic [SCAN_W-1:0]   scan_q;
  logic [DIGITS-1:0]   an_q, an_d, an_act;
  logic [6:0]          seg_q, seg_d, seg_act;
  logic [DIGITS-1:0]   blank;
  logic                upper_zero;
  logic [3:0]          cur_digit;

  // Out-of-range inputs are rejected, so a 9->0 carry only comes from a legal 0.
  assign count_legal = (count_in <= 4'd9);
  assign carry[0]    = (count_q == 4'd9) && (count_in == 4'd0);

  assign value_bcd[3:0] = count_q;

  for (genvar g = 1; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .carry_in  (carry[g-1]),
      .digit     (value_bcd[4*g +: 4]),
      .carry_out (carry[g])
    );
  end

  // Next value of the whole chain, so the display latch tracks without lag.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    value_d      = value_bcd;
    value_d[3:0] = count_legal ? count_in : count_q;
    for (int i = 1; i < DIGITS; i++) begin
      value_d[4*i +: 4] = bcd_next(value_bcd[4*i +: 4], carry[i-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      latch_q    <= '0;
    end else begin
      if (count_legal)       count_q    <= count_in;
      else                   err_q      <= 1'b1;
      if (carry[DIGITS-1])   overflow_q <= 1'b1;
      if (!hold)             latch_q    <= value_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      scan_q  <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      scan_q  <= (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  // Blank position i when it and everything above it are zero.
  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (latch_q[4*i +: 4] == 4'd0);
      blank[i]   = upper_zero;
    end
    cur_digit      = latch_q[{scan_q, 2'b00} +: 4];
    seg_act        = blank[scan_q] ? SEG_BLANK : bcd_to_seg(cur_digit);
    an_act         = '0;
    an_act[scan_q] = 1'b1;
    seg_d          = INV ? ~seg_act : seg_act;
    an_d           = INV ? ~an_act  : an_act;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an_q  <= INV ? ~AN_RST : AN_RST;
      seg_q <= INV ? ~SEG_0  : SEG_0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = INV;
  assign overflow = overflow_q;
  assign err      = err_q;

endmodule

// File: tb/tb_count_display_scan.sv
// Directed bench for count_display_scan: value checks go through a scoreboard
// fed by a decimal reference model; display checks use bench-side patterns.
module tb_count_display_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                hold;
  logic [3:0]          count_in;
  logic [4*DIGITS-1:0] value_bcd;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                overflow;
  logic                err;

  always #5 clk = ~clk;

  count_display_scan #(
    .DIGITS     (DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .hold      (hold),
    .value_bcd (value_bcd),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .overflow  (overflow),
    .err       (err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model in plain decimal: units plus a carried upper count.
  int   m_units;
  int   m_upper;
  logic m_ovf;
  logic m_err;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // Active-low display pattern for a decimal digit.
  function automatic logic [6:0] seg_low(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'b0111111;
      1: p = 7'b0000110;
      2: p = 7'b1011011;
      3: p = 7'b1001111;
      4: p = 7'b1100110;
      5: p = 7'b1101101;
      6: p = 7'b1111101;
      7: p = 7'b0000111;
      8: p = 7'b1111111;
      9: p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return ~p;
  endfunction

  function automatic logic [31:0] model_bcd();
    logic [31:0] r;
    int          v;
    r = '0;
    v = m_upper * 10 + m_units;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed %0h expected none", obs);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c);
    count_in = c;
    if (c > 4'd9) begin
      m_err = 1'b1;
    end else begin
      if (m_units == 9 && c == 4'd0) begin
        m_upper++;
        if (m_upper == 1000) begin
          m_upper = 0;
          m_ovf   = 1'b1;
        end
      end
      m_units = int'(c);
    end
    sb_q.push_back('{"value_bcd", model_bcd()});
    step();
    pop_check(32'(value_bcd));
  endtask

  task automatic count_run(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) drive(4'(c));
  endtask

  task automatic wait_an(input logic [DIGITS-1:0] target, input string tag);
    int n;
    n = 0;
    while (an !== target && n < 64) begin
      step();
      n++;
    end
    check(tag, 32'(an), 32'(target));
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    hold     = 1'b0;
    count_in = 4'd0;
    step();
    m_units = 0;
    m_upper = 0;
    m_ovf   = 1'b0;
    m_err   = 1'b0;
    check("rst_value", 32'(value_bcd), model_bcd());
    check("rst_an", 32'(an), 32'(4'b1110));
    check("rst_seg", 32'(seg), 32'(seg_low(0)));
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    hold     = 1'b0;
    count_in = 4'd0;
    step();

    // Reset values.
    do_reset();
    check("rst_overflow", 32'(overflow), 32'(m_ovf));
    check("rst_err", 32'(err), 32'(m_err));
    check("rst_dp", 32'(dp), 32'(1'b1));

    // First wrap: 0..9 then 0 carries into tens.
    count_run(0, 9);
    drive(4'd0);
    check("first_wrap_ovf", 32'(overflow), 32'(m_ovf));

    // Upstream reset 5->0 gives no carry; out-of-range input sets err and holds.
    drive(4'd5);
    drive(4'd0);
    drive(4'd12);
    check("err_set", 32'(err), 32'(m_err));
    drive(4'd3);
    check("err_sticky", 32'(err), 32'(m_err));

    // Scan order and blanking at 0x0042.
    do_reset();
    for (int k = 0; k < 4; k++) count_run(0, 9);
    count_run(0, 2);
    wait_an(4'b0111, "scan_sync_last");
    wait_an(4'b1110, "scan_sync_first");
    for (int p = 0; p < DIGITS; p++) begin
      for (int r = 0; r < SCAN_DIV; r++) begin
        logic [DIGITS-1:0] an_e;
        logic [6:0]        seg_e;
        an_e    = ~(DIGITS'(1) << p);
        seg_e   = (p == 0) ? seg_low(2) : (p == 1) ? seg_low(4) : 7'h7F;
        sb_q.push_back('{"scan_an_seg", 32'({an_e, seg_e})});
      end
    end
    for (int n = 0; n < DIGITS * SCAN_DIV; n++) begin
      pop_check(32'({an, seg}));
      step();
    end

    // Hold freezes the display while counting continues.
    do_reset();
    count_run(0, 9);
    count_run(0, 3);
    hold = 1'b1;
    count_run(4, 9);
    drive(4'd0);
    wait_an(4'b0111, "hold_sync");
    wait_an(4'b1110, "hold_an0");
    check("hold_seg0", 32'(seg), 32'(seg_low(3)));
    wait_an(4'b1101, "hold_an1");
    check("hold_seg1", 32'(seg), 32'(seg_low(1)));
    hold = 1'b0;
    step();
    step();
    wait_an(4'b0111, "release_sync");
    wait_an(4'b1110, "release_an0");
    check("release_seg0", 32'(seg), 32'(seg_low(0)));
    wait_an(4'b1101, "release_an1");
    check("release_seg1", 32'(seg), 32'(seg_low(2)));

    // Fill to 9999, then wrap the top digit.
    do_reset();
    for (int k = 0; k < 1000; k++) count_run(0, 9);
    check("pre_overflow", 32'(overflow), 32'(m_ovf));
    drive(4'd0);
    check("overflow_set", 32'(overflow), 32'(m_ovf));
    count_run(1, 9);
    drive(4'd0);
    check("overflow_sticky", 32'(overflow), 32'(m_ovf));

    // Reset mid-scan at 0x0567 overrides hold and count_in.
    do_reset();
    for (int k = 0; k < 56; k++) count_run(0, 9);
    count_run(0, 7);
    for (int n = 0; n < 5; n++) step();
    hold     = 1'b1;
    count_in = 4'd9;
    reset    = 1'b0;
    step();
    check("midrst_value", 32'(value_bcd), 32'(0));
    check("midrst_an", 32'(an), 32'(4'b1110));
    check("midrst_seg", 32'(seg), 32'(7'h40));
    check("midrst_overflow", 32'(overflow), 32'(0));
    check("midrst_err", 32'(err), 32'(0));
    check("midrst_dp", 32'(dp), 32'(1'b1));
    reset = 1'b1;
    hold  = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
